// File: rtl/header_decoder_stream.sv
// header_decoder_stream
// Streaming header detector for the SFP receive word stream. Valid-qualified
// 16-bit words are shifted into a window. A preamble word followed by N_HDR
// tagged words is a header. The block decodes the timestamp, spill, slot,
// crate and event fields, checks event-number continuity within a spill and
// keeps saturating statistics. After an accepted header, a lockout window
// keeps payload words from re-triggering the detector.
module header_decoder_stream #(
  parameter int          N_HDR    = 6,
  parameter logic [15:0] PRE_WORD = 16'h0000,
  parameter logic [1:0]  TAG      = 2'b11,
  parameter int          LOCKOUT  = 16,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      data_in,
  input  logic             data_valid,
  input  logic             check_en,
  input  logic             clr_cnt,
  output logic             get_package,
  output logic [28:0]      r_timestamp,
  output logic [9:0]       r_spillno,
  output logic [4:0]       r_slotno,
  output logic [4:0]       r_crateno,
  output logic [15:0]      r_evtno,
  output logic             evt_seq_err,
  output logic             spill_new,
  output logic             locked,
  output logic [CNT_W-1:0] hdr_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT + 1) : 1;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LOCK_W-1:0]  lockCnt_q, lockCnt_d;

  logic [15:0]        win_q [N_HDR];
  logic [15:0]        win   [N_HDR+1];

  logic               match;
  logic               accept;

  logic [28:0]        tsNext;
  logic [9:0]         spillNext;
  logic [4:0]         slotNext;
  logic [4:0]         crateNext;
  logic [15:0]        evtNext;
  logic               spillNewNext;
  logic               seqErrNext;

  logic               getPkg_q;
  logic               seqErr_q;
  logic               spillNew_q;
  logic [28:0]        timestamp_q;
  logic [9:0]         spillNo_q;
  logic [4:0]         slotNo_q;
  logic [4:0]         crateNo_q;
  logic [15:0]        evtNo_q;
  logic               hist_q;
  logic [9:0]         prevSpill_q;
  logic [15:0]        prevEvt_q;
  logic [CNT_W-1:0]   hdrCnt_q;
  logic [CNT_W-1:0]   seqErrCnt_q;

  // Full view of the window: stored words plus the word arriving this beat.
  always_comb begin
    for (int i = 0; i < N_HDR; i++) begin
      win[i] = win_q[i];
    end
    win[N_HDR] = data_in;
  end

  // Shift the stored words by one on every valid beat; frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_HDR; i++) begin
        win_q[i] <= '0;
      end
    end else if (data_valid) begin
      for (int i = 0; i < N_HDR; i++) begin
        win_q[i] <= win[i+1];
      end
    end
  end

  // A header is present when the oldest word is the preamble and all later words carry the tag.
  always_comb begin
    match = data_valid && (win[0] == PRE_WORD);
    for (int k = 1; k <= N_HDR; k++) begin
      if (win[k][15:14] != TAG) begin
        match = 1'b0;
      end
    end
  end

  // Field extraction from the window; win[1] is header word 0.
  always_comb begin
    tsNext    = {win[5][8:0], win[4][13:0], win[3][13:8]};
    spillNext = {win[2][5:0], win[1][13:10]};
    slotNext  = win[1][9:5];
    crateNext = win[1][4:0];
    evtNext   = {win[3][7:0], win[2][13:6]};
  end

  // Spill change and sequence-error judgement against the previous accepted header.
  always_comb begin
    spillNewNext = !hist_q || (spillNext != prevSpill_q);
    seqErrNext   = check_en && hist_q && (spillNext == prevSpill_q) &&
                   (evtNext != (prevEvt_q + 16'd1));
  end

  // Hunt/lock state register together with the lockout down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      lockCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  // Accept a match only while hunting; lockout counts valid beats and ignores matches.
  always_comb begin
    state_d   = state_q;
    lockCnt_d = lockCnt_q;
    accept    = 1'b0;
    case (state_q)
      HUNT: begin
        if (match && !getPkg_q) begin
          accept = 1'b1;
          if (LOCKOUT > 0) begin
            state_d   = LOCK;
            lockCnt_d = LOCK_W'(LOCKOUT);
          end
        end
      end
      LOCK: begin
        if (data_valid) begin
          lockCnt_d = lockCnt_q - 1'b1;
          if (lockCnt_q == LOCK_W'(1)) begin
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // Register the decoded header and its pulses; fields hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      getPkg_q    <= 1'b0;
      seqErr_q    <= 1'b0;
      spillNew_q  <= 1'b0;
      timestamp_q <= '0;
      spillNo_q   <= '0;
      slotNo_q    <= '0;
      crateNo_q   <= '0;
      evtNo_q     <= '0;
      hist_q      <= 1'b0;
      prevSpill_q <= '0;
      prevEvt_q   <= '0;
    end else begin
      getPkg_q   <= accept;
      seqErr_q   <= accept && seqErrNext;
      spillNew_q <= accept && spillNewNext;
      if (accept) begin
        timestamp_q <= tsNext;
        spillNo_q   <= spillNext;
        slotNo_q    <= slotNext;
        crateNo_q   <= crateNext;
        evtNo_q     <= evtNext;
        hist_q      <= 1'b1;
        prevSpill_q <= spillNext;
        prevEvt_q   <= evtNext;
      end
    end
  end

  // Saturating statistics; a clear beats any increment on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdrCnt_q    <= '0;
      seqErrCnt_q <= '0;
    end else if (clr_cnt) begin
      hdrCnt_q    <= '0;
      seqErrCnt_q <= '0;
    end else begin
      if (accept && (hdrCnt_q != '1)) begin
        hdrCnt_q <= hdrCnt_q + CNT_W'(1);
      end
      if (accept && seqErrNext && (seqErrCnt_q != '1)) begin
        seqErrCnt_q <= seqErrCnt_q + CNT_W'(1);
      end
    end
  end

  assign get_package = getPkg_q;
  assign evt_seq_err = seqErr_q;
  assign spill_new   = spillNew_q;
  assign r_timestamp = timestamp_q;
  assign r_spillno   = spillNo_q;
  assign r_slotno    = slotNo_q;
  assign r_crateno   = crateNo_q;
  assign r_evtno     = evtNo_q;
  assign locked      = (state_q == LOCK);
  assign hdr_cnt     = hdrCnt_q;
  assign seq_err_cnt = seqErrCnt_q;

endmodule

// File: tb/tb_header_decoder_stream.sv
// tb_header_decoder_stream
// Drives directed and random word streams into header_decoder_stream. A
// reference model predicts each accepted header from the stream history and
// queues it. A monitor on the falling edge pops and compares every pulse, and
// it checks the held fields, the lock flag and the counters on each cycle.
module tb_header_decoder_stream;

  localparam int N_HDR   = 6;
  localparam int LOCKOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      data_in = '0;
  logic             data_valid = 1'b0;
  logic             check_en = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             get_package;
  logic [28:0]      r_timestamp;
  logic [9:0]       r_spillno;
  logic [4:0]       r_slotno;
  logic [4:0]       r_crateno;
  logic [15:0]      r_evtno;
  logic             evt_seq_err;
  logic             spill_new;
  logic             locked;
  logic [CNT_W-1:0] hdr_cnt;
  logic [CNT_W-1:0] seq_err_cnt;

  header_decoder_stream #(
    .N_HDR   (N_HDR),
    .PRE_WORD(16'h0000),
    .TAG     (2'b11),
    .LOCKOUT (LOCKOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .check_en   (check_en),
    .clr_cnt    (clr_cnt),
    .get_package(get_package),
    .r_timestamp(r_timestamp),
    .r_spillno  (r_spillno),
    .r_slotno   (r_slotno),
    .r_crateno  (r_crateno),
    .r_evtno    (r_evtno),
    .evt_seq_err(evt_seq_err),
    .spill_new  (spill_new),
    .locked     (locked),
    .hdr_cnt    (hdr_cnt),
    .seq_err_cnt(seq_err_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] ts;
    logic [9:0]  spill;
    logic [4:0]  slot;
    logic [4:0]  crate;
    logic [15:0] evt;
    logic        seqErr;
    logic        spillNew;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        hold;
  int          nVec = 0;
  int          nFail = 0;
  int          cyc = 0;
  int          pkts = 0;
  bit          monOn = 1'b0;
  bit          prevPulse = 1'b0;

  // Reference model state: the last N_HDR valid words, lockout beats left, history, counters.
  logic [15:0] mWin[$];
  int          lockLeft;
  bit          mHist;
  logic [9:0]  mSpill;
  logic [15:0] mEvt;
  int          mHdr;
  int          mSeq;
  bit          visLocked = 1'b0;
  int          visHdr = 0;
  int          visSeq = 0;

  logic [4:0]  lastSlot;
  logic [4:0]  lastCrate;
  logic        lastSeq;
  logic        lastSpillNew;

  // Cycle counter used to timestamp when each pulse is due.
  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Return the model to the post-reset picture: zeroed window, no history, no lockout.
  task automatic resetModel();
    mWin.delete();
    for (int i = 0; i < N_HDR; i++) mWin.push_back(16'h0000);
    lockLeft = 0;
    mHist    = 1'b0;
    mSpill   = '0;
    mEvt     = '0;
    mHdr     = 0;
    mSeq     = 0;
  endtask

  // Drive one cycle of input and let the model predict the DUT's reaction to it.
  task automatic applyStimulus(input logic [15:0] d, input logic v);
    logic [15:0] w [N_HDR+1];
    bit          acc;
    bit          tagsOk;
    exp_t        e;
    logic [15:0] nextEvt;
    data_in    = d;
    data_valid = v;
    acc        = 1'b0;
    e          = '{default: 0};
    if (v) begin
      for (int i = 0; i < N_HDR; i++) w[i] = mWin[i];
      w[N_HDR] = d;
      if (lockLeft > 0) begin
        lockLeft--;
      end else begin
        tagsOk = 1'b1;
        for (int k = 1; k <= N_HDR; k++) if (w[k][15:14] != 2'b11) tagsOk = 1'b0;
        if (w[0] == 16'h0000 && tagsOk) begin
          acc        = 1'b1;
          lockLeft   = LOCKOUT;
          e.ts       = {w[5][8:0], w[4][13:0], w[3][13:8]};
          e.spill    = {w[2][5:0], w[1][13:10]};
          e.slot     = w[1][9:5];
          e.crate    = w[1][4:0];
          e.evt      = {w[3][7:0], w[2][13:6]};
          nextEvt    = mEvt + 16'd1;
          e.spillNew = !mHist || (e.spill != mSpill);
          e.seqErr   = check_en && mHist && (e.spill == mSpill) && (e.evt != nextEvt);
          e.cyc      = cyc + 1;
          mHist      = 1'b1;
          mSpill     = e.spill;
          mEvt       = e.evt;
          sb.push_back(e);
        end
      end
      void'(mWin.pop_front());
      mWin.push_back(d);
    end
    if (clr_cnt) begin
      mHdr = 0;
      mSeq = 0;
    end else begin
      if (acc && mHdr < CNT_MAX) mHdr++;
      if (acc && e.seqErr && mSeq < CNT_MAX) mSeq++;
    end
    @(posedge clk);
    visLocked = (lockLeft > 0);
    visHdr    = mHdr;
    visSeq    = mSeq;
    #1;
  endtask

  // Assert reset for two cycles and clear every expectation with it.
  task automatic doReset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    clr_cnt    = 1'b0;
    resetModel();
    sb.delete();
    hold      = '{default: 0};
    visLocked = 1'b0;
    visHdr    = 0;
    visSeq    = 0;
    prevPulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    monOn = 1'b1;
  endtask

  task automatic pad(input int n);
    repeat (n) applyStimulus(16'h1111, 1'b1);
  endtask

  // Build and send preamble + six header words; options for gaps, a bad word, clear and reset.
  task automatic sendHdr(input logic [15:0] pre, input logic [9:0] sp, input logic [4:0] sl,
                         input logic [4:0] cr, input logic [15:0] ev, input bit toggle,
                         input bit clrLast, input int badIdx, input int rstAfter);
    logic [15:0] hw [7];
    logic [28:0] ts;
    ts    = 29'($urandom);
    hw[0] = pre;
    hw[1] = {2'b11, sp[3:0], sl, cr};
    hw[2] = {2'b11, ev[7:0], sp[9:4]};
    hw[3] = {2'b11, ts[5:0], ev[15:8]};
    hw[4] = {2'b11, ts[19:6]};
    hw[5] = {2'b11, 5'($urandom), ts[28:20]};
    hw[6] = {2'b11, 14'($urandom)};
    if (badIdx >= 1 && badIdx <= 6) hw[badIdx][15:14] = 2'b10;
    for (int i = 0; i < 7; i++) begin
      clr_cnt = clrLast && (i == 6);
      applyStimulus(hw[i], 1'b1);
      clr_cnt = 1'b0;
      if (i == rstAfter) doReset();
      if (toggle) applyStimulus(16'h0000, 1'b0);
    end
  endtask

  // Monitor: pop and compare each pulse, and check held fields, lock and counters every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (monOn) begin
      checkOutput("locked", 32'(locked), 32'(visLocked));
      checkOutput("hdr_cnt", 32'(hdr_cnt), 32'(visHdr));
      checkOutput("seq_err_cnt", 32'(seq_err_cnt), 32'(visSeq));
      if (get_package) begin
        pkts++;
        if (prevPulse) checkOutput("back_to_back", 32'd1, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("r_timestamp", 32'(r_timestamp), 32'(e.ts));
          checkOutput("r_spillno", 32'(r_spillno), 32'(e.spill));
          checkOutput("r_slotno", 32'(r_slotno), 32'(e.slot));
          checkOutput("r_crateno", 32'(r_crateno), 32'(e.crate));
          checkOutput("r_evtno", 32'(r_evtno), 32'(e.evt));
          checkOutput("evt_seq_err", 32'(evt_seq_err), 32'(e.seqErr));
          checkOutput("spill_new", 32'(spill_new), 32'(e.spillNew));
          hold = e;
        end
        lastSlot     = r_slotno;
        lastCrate    = r_crateno;
        lastSeq      = evt_seq_err;
        lastSpillNew = spill_new;
      end else begin
        checkOutput("evt_seq_err_idle", 32'(evt_seq_err), 32'd0);
        checkOutput("spill_new_idle", 32'(spill_new), 32'd0);
        checkOutput("hold_timestamp", 32'(r_timestamp), 32'(hold.ts));
        checkOutput("hold_spillno", 32'(r_spillno), 32'(hold.spill));
        checkOutput("hold_slotno", 32'(r_slotno), 32'(hold.slot));
        checkOutput("hold_crateno", 32'(r_crateno), 32'(hold.crate));
        checkOutput("hold_evtno", 32'(r_evtno), 32'(hold.evt));
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          checkOutput("pulse_missing", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
      prevPulse = get_package;
    end
  end

  // Directed scenarios followed by a randomized stream, then the summary.
  initial begin
    int p0;
    logic [9:0]  rs;
    logic [15:0] re;
    resetModel();
    doReset();
    checkOutput("reset_get_package", 32'(get_package), 32'd0);
    checkOutput("reset_evtno", 32'(r_evtno), 32'd0);
    checkOutput("reset_locked", 32'(locked), 32'd0);

    // Basic decode of a single header.
    check_en = 1'b1;
    p0 = pkts;
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'h0010, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t1_pulses", 32'(pkts - p0), 32'd1);
    checkOutput("t1_slot", 32'(lastSlot), 32'd3);
    checkOutput("t1_crate", 32'(lastCrate), 32'd2);
    checkOutput("t1_spill_new", 32'(lastSpillNew), 32'd1);
    checkOutput("t1_seq_err", 32'(lastSeq), 32'd0);
    checkOutput("t1_hdr_cnt", 32'(hdr_cnt), 32'd1);

    // Event gap within a spill with checking on, then off.
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'h0012, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t2_seq_err", 32'(lastSeq), 32'd1);
    checkOutput("t2_seq_err_cnt", 32'(seq_err_cnt), 32'd1);
    checkOutput("t2_spill_new", 32'(lastSpillNew), 32'd0);
    check_en = 1'b0;
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'h0020, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t2_no_check", 32'(lastSeq), 32'd0);

    // Event-number wrap and spill change.
    check_en = 1'b1;
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'hFFFF, 1'b0, 1'b0, -1, -1);
    pad(18);
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'h0000, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t3_wrap", 32'(lastSeq), 32'd0);
    sendHdr(16'h0000, 10'h005, 5'd3, 5'd2, 16'h0005, 1'b0, 1'b0, -1, -1);
    pad(18);
    sendHdr(16'h0000, 10'h006, 5'd3, 5'd2, 16'h0009, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t3_spill_new", 32'(lastSpillNew), 32'd1);
    checkOutput("t3_spill_seq", 32'(lastSeq), 32'd0);

    // Lockout: a header completing 10 beats after a match is ignored, 20 beats after is taken.
    p0 = pkts;
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0001, 1'b0, 1'b0, -1, -1);
    pad(3);
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0002, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t4_lock_ignore", 32'(pkts - p0), 32'd1);
    p0 = pkts;
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0003, 1'b0, 1'b0, -1, -1);
    pad(13);
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0004, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t4_lock_expire", 32'(pkts - p0), 32'd2);

    // Valid toggling every cycle through a header.
    p0 = pkts;
    sendHdr(16'h0000, 10'h2A5, 5'd17, 5'd9, 16'h0005, 1'b1, 1'b0, -1, -1);
    pad(18);
    checkOutput("t5_pulses", 32'(pkts - p0), 32'd1);
    checkOutput("t5_slot", 32'(lastSlot), 32'd17);
    checkOutput("t5_crate", 32'(lastCrate), 32'd9);

    // Bad preamble and a bad tag must not trigger.
    p0 = pkts;
    sendHdr(16'h0001, 10'h007, 5'd1, 5'd1, 16'h0006, 1'b0, 1'b0, -1, -1);
    pad(18);
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0007, 1'b0, 1'b0, 3, -1);
    pad(18);
    checkOutput("t6_no_pulse", 32'(pkts - p0), 32'd0);

    // Reset after w3 discards the header and forgets history.
    p0 = pkts;
    sendHdr(16'h0000, 10'h007, 5'd1, 5'd1, 16'h0008, 1'b0, 1'b0, -1, 4);
    pad(18);
    checkOutput("t7_no_pulse", 32'(pkts - p0), 32'd0);
    sendHdr(16'h0000, 10'h007, 5'd4, 5'd4, 16'h0009, 1'b0, 1'b0, -1, -1);
    pad(18);
    checkOutput("t7_spill_new", 32'(lastSpillNew), 32'd1);
    checkOutput("t7_hdr_cnt", 32'(hdr_cnt), 32'd1);

    // Saturation, then a clear on the accepting beat.
    for (int i = 0; i < 16; i++) begin
      sendHdr(16'h0000, 10'h008, 5'd2, 5'd2, 16'(i), 1'b0, 1'b0, -1, -1);
      pad(17);
    end
    checkOutput("t8_saturate", 32'(hdr_cnt), 32'(CNT_MAX));
    sendHdr(16'h0000, 10'h008, 5'd2, 5'd2, 16'h0100, 1'b0, 1'b1, -1, -1);
    pad(18);
    checkOutput("t8_clear_wins", 32'(hdr_cnt), 32'd0);

    // Random mixture of headers, payload, valid gaps, check_en and clears.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        check_en = 1'($urandom_range(0, 1));
        rs = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h00C;
        re = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'(mEvt + 16'd1);
        sendHdr(16'h0000, rs, 5'($urandom), 5'($urandom), re, 1'($urandom_range(0, 1)),
                1'b0, -1, -1);
      end else begin
        for (int j = 0; j < $urandom_range(1, 20); j++) begin
          clr_cnt = ($urandom_range(0, 49) == 0);
          applyStimulus(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                        1'($urandom_range(0, 9) < 8));
          clr_cnt = 1'b0;
        end
      end
    end
    pad(5);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
